// File: rtl/alu_defs_pkg.sv
// Shared encodings for the EX-stage ALU control and multiply/divide unit.
package alu_defs_pkg;

  localparam logic [3:0] ALUC_AND  = 4'b0000;
  localparam logic [3:0] ALUC_OR   = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_XOR  = 4'b0011;
  localparam logic [3:0] ALUC_NOR  = 4'b0100;
  localparam logic [3:0] ALUC_SUB  = 4'b0110;
  localparam logic [3:0] ALUC_SLT  = 4'b0111;
  localparam logic [3:0] ALUC_SLTU = 4'b1000;
  localparam logic [3:0] ALUC_SLL  = 4'b1001;
  localparam logic [3:0] ALUC_SRL  = 4'b1010;
  localparam logic [3:0] ALUC_SRA  = 4'b1011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } mdu_state_t;

  function automatic logic is_mdu_funct(input logic [5:0] f);
    return f inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                     FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract
// step per busy cycle, with the sign correction applied to the final step.
module mdu_iter #(
  parameter int               DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIV0_LO = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              start_div,
  input  logic              start_signed,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              busy,
  input  logic              busy_div,
  output logic              last,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi_w, lo_w, opnd;
  logic                neg_q, neg_r, div0;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W-1:0]   hi_n, lo_n;
  logic [DATA_W:0]     mul_sum, div_part, div_diff;
  logic [2*DATA_W-1:0] prod;

  assign last = busy && (cnt == CNT_W'(DATA_W - 1));

  // Operand magnitudes for signed ops, and one iteration step of whichever op is running.
  always_comb begin
    mag_a    = (start_signed && src_a[DATA_W-1]) ? -src_a : src_a;
    mag_b    = (start_signed && src_b[DATA_W-1]) ? -src_b : src_b;
    mul_sum  = {1'b0, hi_w} + ({(DATA_W+1){lo_w[0]}} & {1'b0, opnd});
    div_part = {hi_w, lo_w[DATA_W-1]};
    div_diff = div_part - {1'b0, opnd};
    hi_n     = mul_sum[DATA_W:1];
    lo_n     = {mul_sum[0], lo_w[DATA_W-1:1]};
    if (busy_div) begin
      if (!div_diff[DATA_W]) begin
        hi_n = div_diff[DATA_W-1:0];
        lo_n = {lo_w[DATA_W-2:0], 1'b1};
      end else begin
        hi_n = div_part[DATA_W-1:0];
        lo_n = {lo_w[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Sign-corrected result of the step in progress; only consumed on the last step.
  always_comb begin
    prod   = {hi_n, lo_n};
    res_hi = hi_n;
    res_lo = lo_n;
    if (busy_div) begin
      res_hi = neg_r ? -hi_n : hi_n;
      res_lo = div0 ? DIV0_LO : (neg_q ? -lo_n : lo_n);
    end else begin
      if (neg_q) prod = -prod;
      res_hi = prod[2*DATA_W-1:DATA_W];
      res_lo = prod[DATA_W-1:0];
    end
  end

  // Load operands on accept, then advance the working registers once per busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      hi_w  <= '0;
      lo_w  <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      hi_w  <= '0;
      lo_w  <= start_div ? mag_a : mag_b;
      opnd  <= start_div ? mag_b : mag_a;
      neg_q <= start_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      neg_r <= start_signed && src_a[DATA_W-1];
      div0  <= start_div && (src_b == '0);
    end else if (busy) begin
      hi_w <= hi_n;
      lo_w <= lo_n;
      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage control: ALU opcode decode, MDU issue/stall handshake, HI/LO registers.
module alu_ctrl_mdu
  import alu_defs_pkg::*;
#(
  parameter int               DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIV0_LO = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic              ex_valid,
  input  logic              ex_flush,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [3:0]        alucontrol,
  output logic              illegal_fn,
  output logic              hilo_wb,
  output logic [DATA_W-1:0] hilo_data,
  output logic              mdu_stall
);

  mdu_state_t        state, state_next;
  logic              mdu_op, acc, is_mul, is_div, start, last;
  logic              rd_hi, rd_lo;
  logic [DATA_W-1:0] hi, lo, res_hi, res_lo;

  assign mdu_op    = ex_valid && !ex_flush && (aluop == ALUOP_FUNCT) && is_mdu_funct(funct);
  assign acc       = mdu_op && (state == ST_IDLE);
  assign mdu_stall = mdu_op && (state != ST_IDLE);
  assign is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign is_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign start     = acc && (is_mul || is_div);
  assign rd_hi     = ex_valid && (aluop == ALUOP_FUNCT) && (funct == FUNCT_MFHI);
  assign rd_lo     = ex_valid && (aluop == ALUOP_FUNCT) && (funct == FUNCT_MFLO);
  assign hilo_wb   = acc && (rd_hi || rd_lo);
  assign hilo_data = rd_hi ? hi : (rd_lo ? lo : '0);

  // Decode aluop/funct into the ALU opcode; unknown functs fall back to AND and flag illegal.
  always_comb begin
    alucontrol = ALUC_AND;
    illegal_fn = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUC_ADD;
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_SLT: alucontrol = ALUC_SLT;
      default: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: alucontrol = ALUC_ADD;
          FUNCT_SUB, FUNCT_SUBU: alucontrol = ALUC_SUB;
          FUNCT_AND:             alucontrol = ALUC_AND;
          FUNCT_OR:              alucontrol = ALUC_OR;
          FUNCT_XOR:             alucontrol = ALUC_XOR;
          FUNCT_NOR:             alucontrol = ALUC_NOR;
          FUNCT_SLT:             alucontrol = ALUC_SLT;
          FUNCT_SLTU:            alucontrol = ALUC_SLTU;
          FUNCT_SLL:             alucontrol = ALUC_SLL;
          FUNCT_SRL:             alucontrol = ALUC_SRL;
          FUNCT_SRA:             alucontrol = ALUC_SRA;
          default: begin
            if (is_mdu_funct(funct)) alucontrol = ALUC_ADD;
            else                     illegal_fn = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Next MDU state: start on an accepted mult/div, return to idle after the last step.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = is_div ? ST_DIV : ST_MUL;
      end
      ST_MUL, ST_DIV: begin
        if (last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // MDU state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // HI/LO: written by the final iteration or by an accepted mthi/mtlo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (last) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (acc && (funct == FUNCT_MTHI)) begin
      hi <= src_a;
    end else if (acc && (funct == FUNCT_MTLO)) begin
      lo <= src_a;
    end
  end

  mdu_iter #(
    .DATA_W (DATA_W),
    .DIV0_LO(DIV0_LO)
  ) u_mdu_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_div   (is_div),
    .start_signed((funct == FUNCT_MULT) || (funct == FUNCT_DIV)),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (state != ST_IDLE),
    .busy_div    (state == ST_DIV),
    .last        (last),
    .res_hi      (res_hi),
    .res_lo      (res_lo)
  );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: arithmetic reference model plus directed vectors.
module tb_alu_ctrl_mdu;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  aluop = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic        ex_valid = 1'b0;
  logic        ex_flush = 1'b0;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic [3:0]  alucontrol;
  logic        illegal_fn, hilo_wb, mdu_stall;
  logic [31:0] hilo_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_hi = 32'h0, m_lo = 32'h0, pend_hi = 32'h0, pend_lo = 32'h0;
  int          busy_left = 0;

  alu_ctrl_mdu #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .aluop     (aluop),
    .funct     (funct),
    .ex_valid  (ex_valid),
    .ex_flush  (ex_flush),
    .src_a     (src_a),
    .src_b     (src_b),
    .alucontrol(alucontrol),
    .illegal_fn(illegal_fn),
    .hilo_wb   (hilo_wb),
    .hilo_data (hilo_data),
    .mdu_stall (mdu_stall)
  );

  always #5 clk = ~clk;

  function automatic bit is_mdu(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  // Expected {illegal_fn, alucontrol} straight from the opcode table.
  function automatic logic [4:0] exp_decode(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b11) return 5'b0_0111;
    case (f)
      6'b100000, 6'b100001: return 5'b0_0010;
      6'b100010, 6'b100011: return 5'b0_0110;
      6'b100100: return 5'b0_0000;
      6'b100101: return 5'b0_0001;
      6'b100110: return 5'b0_0011;
      6'b100111: return 5'b0_0100;
      6'b101010: return 5'b0_0111;
      6'b101011: return 5'b0_1000;
      6'b000000: return 5'b0_1001;
      6'b000010: return 5'b0_1010;
      6'b000011: return 5'b0_1011;
      default:   return is_mdu(f) ? 5'b0_0010 : 5'b1_0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] f, input logic v,
                               input logic fl, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    aluop = op; funct = f; ex_valid = v; ex_flush = fl; src_a = a; src_b = b;
  endtask

  // Issue mfhi/mflo until it is no longer stalled; returns the value and the stall count.
  task automatic readHiLo(input logic [5:0] f, output logic [31:0] val, output int stalls);
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(2'b10, f, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      if (!mdu_stall) break;
      stalls++;
    end
    if (mdu_stall) begin
      checks++;
      errors++;
      $display("[TB] FAIL read_timeout: got stall still high expected release within 64 cycles");
    end
    val = hilo_data;
  endtask

  // Reference model: the MDU result appears 32 edges after an accepted mult/div.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = 32'h0; m_lo = 32'h0; busy_left = 0;
    end else begin
      logic [63:0] p;
      int sa, sb;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin m_hi = pend_hi; m_lo = pend_lo; end
      end else if (ex_valid && !ex_flush && aluop == 2'b10 && is_mdu(funct)) begin
        sa = src_a; sb = src_b;
        case (funct)
          F_MTHI: m_hi = src_a;
          F_MTLO: m_lo = src_a;
          F_MULT: begin
            p = longint'(sa) * longint'(sb);
            {pend_hi, pend_lo} = p; busy_left = 32;
          end
          F_MULTU: begin
            p = {32'h0, src_a} * {32'h0, src_b};
            {pend_hi, pend_lo} = p; busy_left = 32;
          end
          F_DIV: begin
            if (src_b == 0) begin pend_lo = 32'hFFFFFFFF; pend_hi = src_a; end
            else begin pend_lo = sa / sb; pend_hi = sa % sb; end
            busy_left = 32;
          end
          F_DIVU: begin
            if (src_b == 0) begin pend_lo = 32'hFFFFFFFF; pend_hi = src_a; end
            else begin pend_lo = src_a / src_b; pend_hi = src_a % src_b; end
            busy_left = 32;
          end
          default: ;
        endcase
      end
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0]  d;
      logic [31:0] exp_data;
      bit          op_m, rd;
      d    = exp_decode(aluop, funct);
      op_m = ex_valid && !ex_flush && aluop == 2'b10 && is_mdu(funct);
      rd   = (funct == F_MFHI) || (funct == F_MFLO);
      exp_data = 32'h0;
      if (ex_valid && aluop == 2'b10 && funct == F_MFHI) exp_data = m_hi;
      if (ex_valid && aluop == 2'b10 && funct == F_MFLO) exp_data = m_lo;
      checkOutput("alucontrol", {28'h0, alucontrol}, {28'h0, d[3:0]});
      checkOutput("illegal_fn", {31'h0, illegal_fn}, {31'h0, d[4]});
      checkOutput("mdu_stall", {31'h0, mdu_stall}, {31'h0, op_m && busy_left > 0});
      checkOutput("hilo_wb", {31'h0, hilo_wb}, {31'h0, op_m && busy_left == 0 && rd});
      checkOutput("hilo_data", hilo_data, exp_data);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int          st;

    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    applyStimulus(2'b10, F_MFHI, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("reset_stall", {31'h0, mdu_stall}, 32'h0);
    checkOutput("reset_hi", hilo_data, 32'h0);
    #2 rst_n = 1'b1;

    for (int op = 0; op < 4; op++)
      for (int f = 0; f < 64; f++)
        applyStimulus(op[1:0], f[5:0], 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1);

    applyStimulus(2'b10, 6'b111111, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("fn3f_code", {28'h0, alucontrol}, 32'h0);
    checkOutput("fn3f_illegal", {31'h0, illegal_fn}, 32'h1);
    applyStimulus(2'b10, 6'b101011, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("sltu_code", {28'h0, alucontrol}, 32'h8);

    applyStimulus(2'b10, F_MULTU, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h2);
    readHiLo(F_MFHI, v, st);
    checkOutput("multu_stalls", st, 32);
    checkOutput("multu_hi", v, 32'h1);
    readHiLo(F_MFLO, v, st);
    checkOutput("multu_lo", v, 32'hFFFFFFFE);

    applyStimulus(2'b10, F_MULT, 1'b1, 1'b0, 32'hFFFFFFFD, 32'h5);
    readHiLo(F_MFHI, v, st);
    checkOutput("mult_hi", v, 32'hFFFFFFFF);
    readHiLo(F_MFLO, v, st);
    checkOutput("mult_lo", v, 32'hFFFFFFF1);

    applyStimulus(2'b10, F_DIV, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h2);
    readHiLo(F_MFLO, v, st);
    checkOutput("div_lo", v, 32'hFFFFFFFD);
    readHiLo(F_MFHI, v, st);
    checkOutput("div_hi", v, 32'hFFFFFFFF);

    applyStimulus(2'b10, F_DIVU, 1'b1, 1'b0, 32'd100, 32'h0);
    readHiLo(F_MFLO, v, st);
    checkOutput("divu0_stalls", st, 32);
    checkOutput("divu0_lo", v, 32'hFFFFFFFF);
    readHiLo(F_MFHI, v, st);
    checkOutput("divu0_hi", v, 32'd100);

    applyStimulus(2'b10, F_MULT, 1'b1, 1'b0, 32'd6, 32'd7);
    applyStimulus(2'b00, 6'b100000, 1'b1, 1'b0, 32'd1, 32'd2);
    @(negedge clk);
    checkOutput("add_busy_stall", {31'h0, mdu_stall}, 32'h0);
    checkOutput("add_busy_code", {28'h0, alucontrol}, 32'h2);
    applyStimulus(2'b10, F_MFLO, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("mflo_busy_stall", {31'h0, mdu_stall}, 32'h1);
    readHiLo(F_MFLO, v, st);
    checkOutput("mult67_lo", v, 32'd42);

    applyStimulus(2'b10, F_MTHI, 1'b1, 1'b0, 32'h1234, 32'h0);
    readHiLo(F_MFHI, v, st);
    checkOutput("mthi_stalls", st, 0);
    checkOutput("mthi_hi", v, 32'h1234);
    applyStimulus(2'b10, F_MTLO, 1'b1, 1'b0, 32'h55AA, 32'h0);
    readHiLo(F_MFLO, v, st);
    checkOutput("mtlo_lo", v, 32'h55AA);

    applyStimulus(2'b10, F_MULT, 1'b1, 1'b1, 32'd7, 32'd9);
    readHiLo(F_MFHI, v, st);
    checkOutput("flush_stalls", st, 0);
    checkOutput("flush_hi", v, 32'h1234);
    readHiLo(F_MFLO, v, st);
    checkOutput("flush_lo", v, 32'h55AA);

    applyStimulus(2'b10, F_DIV, 1'b1, 1'b0, 32'd1000, 32'd7);
    repeat (10) applyStimulus(2'b10, F_MFHI, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("middiv_stall", {31'h0, mdu_stall}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_stall", {31'h0, mdu_stall}, 32'h0);
    checkOutput("async_hi", hilo_data, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    readHiLo(F_MFLO, v, st);
    checkOutput("post_rst_lo", v, 32'h0);

    applyStimulus(2'b10, F_DIV, 1'b1, 1'b0, 32'hFFFFFF9C, 32'd7);
    readHiLo(F_MFLO, v, st);
    checkOutput("div2_stalls", st, 32);
    checkOutput("div2_lo", v, 32'hFFFFFFF2);
    readHiLo(F_MFHI, v, st);
    checkOutput("div2_hi", v, 32'hFFFFFFFE);

    applyStimulus(2'b00, 6'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
